// File: rtl/fnc_vga_pkg.sv
// Shared VGA timing defaults, control-word layout and timing helpers for
// the scan-out family of video blocks.
package fnc_vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CH_W     = 4;
  localparam int unsigned LINE_W       = 10;

  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync);
    return act + fp + sync;
  endfunction

  localparam int unsigned DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_def_t;

  // Counter-derived control word that travels down the read-latency delay line.
  typedef struct packed {
    logic              hsync;
    logic              vsync;
    logic              hblank;
    logic              vblank;
    logic              run;
    logic [LINE_W-1:0] line_no;
  } vga_ctl_t;

endpackage

// File: rtl/fnc_vga_timing.sv
// Free-running horizontal/vertical raster counters with combinational sync,
// blank and line/frame-end strobes derived from them.
module fnc_vga_timing
  import fnc_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned HW       = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VW       = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          line_end,
  output logic          frame_end
);

  localparam int unsigned H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int unsigned HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int unsigned VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  int unsigned h;
  int unsigned v;

  assign h = 32'(hcnt);
  assign v = 32'(vcnt);

  assign line_end  = (h == H_TOTAL - 1);
  assign frame_end = line_end && (v == V_TOTAL - 1);
  assign hblank    = (h >= H_ACTIVE);
  assign vblank    = (v >= V_ACTIVE);
  assign hsync     = (h >= HS_START && h < HS_END) ? HS_POL : ~HS_POL;
  assign vsync     = (v >= VS_START && v < VS_END) ? VS_POL : ~VS_POL;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnc_vga_scanout.sv
// Parametrised VGA scan-out: fetches pixels ahead of the beam and delays the
// raster controls so sync/blank line up with the returned VRAM data.
module fnc_vga_scanout
  import fnc_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CH_W     = DEF_CH_W,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned SCALE    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                module_en,
  input  logic [3*CH_W-1:0]   bg_color,
  output logic [ADDR_W-1:0]   addr,
  input  logic [3*CH_W-1:0]   data,
  output logic                hsync,
  output logic                vsync,
  output logic                hbrank,
  output logic                vbrank,
  output logic [CH_W-1:0]     rdata,
  output logic [CH_W-1:0]     gdata,
  output logic [CH_W-1:0]     bdata,
  output logic                frame_irq,
  output logic [LINE_W-1:0]   line_no
);

  localparam int unsigned HW         = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VW         = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned LINE_STEP  = H_ACTIVE >> SCALE;
  localparam int unsigned SCALE_MASK = (1 << SCALE) - 1;
  localparam longint unsigned FB_PIXELS = longint'(V_ACTIVE >> SCALE) * longint'(LINE_STEP);

  localparam vga_ctl_t CTL_RST = '{hsync: ~HS_POL, vsync: ~VS_POL, hblank: 1'b1,
                                   vblank: 1'b1, run: 1'b0, line_no: '0};

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("fnc_vga_scanout: RD_LAT must be 1..4");
  end
  if (SCALE > 2) begin : g_bad_scale
    $error("fnc_vga_scanout: SCALE must be 0..2");
  end
  if (FB_PIXELS > (64'd1 << ADDR_W)) begin : g_addr_overflow
    $error("fnc_vga_scanout: frame buffer does not fit in ADDR_W");
  end

  logic [HW-1:0]       hcnt;
  logic [VW-1:0]       vcnt;
  logic                t_hsync;
  logic                t_vsync;
  logic                t_hblank;
  logic                t_vblank;
  logic                line_end;
  logic                frame_end;
  logic                run;
  logic [ADDR_W-1:0]   line_base;
  logic [3*CH_W-1:0]   rgb;
  logic [3*CH_W-1:0]   pix_next;
  vga_ctl_t            ctl_now;
  vga_ctl_t            pipe [RD_LAT+1];

  fnc_vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hsync     (t_hsync),
    .vsync     (t_vsync),
    .hblank    (t_hblank),
    .vblank    (t_vblank),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  always_comb begin
    ctl_now         = CTL_RST;
    ctl_now.hsync   = t_hsync;
    ctl_now.vsync   = t_vsync;
    ctl_now.hblank  = t_hblank;
    ctl_now.vblank  = t_vblank;
    ctl_now.run     = run;
    ctl_now.line_no = LINE_W'(vcnt);
  end

  // Replicated rows reuse the same line_base until the last copy of the row ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      line_base <= '0;
      addr      <= '0;
    end else begin
      if (frame_end) begin
        run       <= module_en;
        line_base <= '0;
      end else if (line_end && ((vcnt & VW'(SCALE_MASK)) == VW'(SCALE_MASK))) begin
        line_base <= line_base + ADDR_W'(LINE_STEP);
      end
      addr <= run ? line_base + ADDR_W'(hcnt >> SCALE) : '0;
    end
  end

  // Stage RD_LAT-1 selects the pixel so the rgb register lands beside stage RD_LAT.
  always_comb begin
    pix_next = '0;
    if (!pipe[RD_LAT-1].hblank && !pipe[RD_LAT-1].vblank)
      pix_next = pipe[RD_LAT-1].run ? data : bg_color;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= RD_LAT; k++) pipe[k] <= CTL_RST;
      rgb       <= '0;
      frame_irq <= 1'b0;
    end else begin
      pipe[0] <= ctl_now;
      for (int unsigned k = 1; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];
      rgb       <= pix_next;
      frame_irq <= pipe[RD_LAT-1].vblank && !pipe[RD_LAT].vblank && pipe[RD_LAT-1].run;
    end
  end

  assign hsync   = pipe[RD_LAT].hsync;
  assign vsync   = pipe[RD_LAT].vsync;
  assign hbrank  = pipe[RD_LAT].hblank;
  assign vbrank  = pipe[RD_LAT].vblank;
  assign line_no = pipe[RD_LAT].line_no;
  assign rdata   = rgb[3*CH_W-1 -: CH_W];
  assign gdata   = rgb[2*CH_W-1 -: CH_W];
  assign bdata   = rgb[CH_W-1:0];

endmodule

// File: tb/tb_fnc_vga_scanout.sv
// Directed bench for fnc_vga_scanout on a 14x7 raster with several latency
// and replication variants, each fed by a VRAM model returning data=addr.
module tb_fnc_vga_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en = 1'b0;
  logic [11:0] bg_color = 12'hABC;

  logic [19:0] a_m, a_s, a_1, a_3;
  logic [11:0] d_m, d_s, d_1, d_3, d3a;
  logic        hs_m, vs_m, hb_m, vb_m, irq_m;
  logic        hs_s, vs_s, hb_s, vb_s, irq_s;
  logic        hs_1, vs_1, hb_1, vb_1, irq_1;
  logic        hs_3, vs_3, hb_3, vb_3, irq_3;
  logic [3:0]  r_m, g_m, b_m, r_s, g_s, b_s, r_1, g_1, b_1, r_3, g_3, b_3;
  logic [9:0]  ln_m, ln_s, ln_1, ln_3;
  logic [11:0] rgb_m, rgb_s, rgb_1, rgb_3;

  int n = 0;
  int checks = 0;
  int errors = 0;
  int irq_hi = 0;
  int irq_rise = 0;
  logic irq_prev = 1'b0;

  always #5 clk = ~clk;

  assign rgb_m = {r_m, g_m, b_m};
  assign rgb_s = {r_s, g_s, b_s};
  assign rgb_1 = {r_1, g_1, b_1};
  assign rgb_3 = {r_3, g_3, b_3};

  // VRAM models: the DUT rgb register is the last latency stage.
  assign d_1 = 12'(a_1);
  always @(posedge clk) begin
    d_m <= 12'(a_m);
    d_s <= 12'(a_s);
    d3a <= 12'(a_3);
    d_3 <= d3a;
  end

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  always @(negedge clk) begin
    if (!rst && n >= 297 && n <= 590) begin
      if (irq_m) irq_hi++;
      if (irq_m && !irq_prev) irq_rise++;
    end
    irq_prev = irq_m;
  end

  fnc_vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(4), .ADDR_W(20),
    .RD_LAT(2), .SCALE(0)) u_main (
    .clk(clk), .rst(rst), .module_en(module_en), .bg_color(bg_color), .addr(a_m), .data(d_m),
    .hsync(hs_m), .vsync(vs_m), .hbrank(hb_m), .vbrank(vb_m), .rdata(r_m), .gdata(g_m),
    .bdata(b_m), .frame_irq(irq_m), .line_no(ln_m));

  fnc_vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(4), .ADDR_W(20),
    .RD_LAT(2), .SCALE(1)) u_scale (
    .clk(clk), .rst(rst), .module_en(module_en), .bg_color(bg_color), .addr(a_s), .data(d_s),
    .hsync(hs_s), .vsync(vs_s), .hbrank(hb_s), .vbrank(vb_s), .rdata(r_s), .gdata(g_s),
    .bdata(b_s), .frame_irq(irq_s), .line_no(ln_s));

  fnc_vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(4), .ADDR_W(20),
    .RD_LAT(1), .SCALE(0)) u_lat1 (
    .clk(clk), .rst(rst), .module_en(module_en), .bg_color(bg_color), .addr(a_1), .data(d_1),
    .hsync(hs_1), .vsync(vs_1), .hbrank(hb_1), .vbrank(vb_1), .rdata(r_1), .gdata(g_1),
    .bdata(b_1), .frame_irq(irq_1), .line_no(ln_1));

  fnc_vga_scanout #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(4), .ADDR_W(20),
    .RD_LAT(3), .SCALE(0)) u_lat3 (
    .clk(clk), .rst(rst), .module_en(module_en), .bg_color(bg_color), .addr(a_3), .data(d_3),
    .hsync(hs_3), .vsync(vs_3), .hbrank(hb_3), .vbrank(vb_3), .rdata(r_3), .gdata(g_3),
    .bdata(b_3), .frame_irq(irq_3), .line_no(ln_3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic to_cycle(input int t);
    while (n < t) @(negedge clk);
  endtask

  // Hand-picked raster positions (frame 1) around row edges for latency variants.
  function automatic bit edge_col(input int m);
    return (m == 98 || m == 99 || m == 111 || m == 112 || m == 119 || m == 120);
  endfunction

  function automatic logic [31:0] edge_rgb(input int m);
    case (m)
      99:      return 1;
      112:     return 8;
      119:     return 15;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] edge_hb(input int m);
    return (m == 111 || m == 120) ? 1 : 0;
  endfunction

  initial begin
    repeat (5) @(negedge clk);
    check("rst_hsync", hs_m, 1);
    check("rst_vsync", vs_m, 1);
    check("rst_hbrank", hb_m, 1);
    check("rst_vbrank", vb_m, 1);
    check("rst_rgb", rgb_m, 0);
    check("rst_irq", irq_m, 0);
    check("rst_addr", a_m, 0);
    check("rst_line", ln_m, 0);
    rst = 1'b0;

    for (int t = 2; t <= 16; t++) begin
      to_cycle(t);
      check("hsync_line0", hs_m, (t == 13 || t == 14) ? 0 : 1);
      if (t == 2) check("hb_fill", hb_m, 1);
      if (t == 3) begin
        check("bg_first_frame", rgb_m, 12'hABC);
        check("hb_first_px", hb_m, 0);
      end
    end

    to_cycle(40);
    module_en = 1'b1;
    to_cycle(48);
    check("bg_after_en", rgb_m, 12'hABC);
    check("line_no_3", ln_m, 3);

    for (int t = 100; t <= 136; t++) begin
      to_cycle(t);
      if (t == 100) begin
        check("pre_frame_rgb", rgb_m, 0);
        check("pre_frame_vb", vb_m, 1);
      end
      if (t == 101) begin
        check("f1_vbrank", vb_m, 0);
        check("f1_line0", ln_m, 0);
      end
      if (t >= 101 && t <= 108) begin
        check("f1_row0_rgb", rgb_m, t - 101);
        check("scale_row0", rgb_s, (t - 101) >> 1);
      end
      if (t >= 115 && t <= 122) check("scale_row1", rgb_s, (t - 115) >> 1);
      if (t >= 129 && t <= 136) check("scale_row2", rgb_s, 4 + ((t - 129) >> 1));
      if (edge_col(t - 2)) begin
        check("lat1_rgb", rgb_1, edge_rgb(t - 2));
        check("lat1_hb", hb_1, edge_hb(t - 2));
      end
      if (edge_col(t - 4)) begin
        check("lat3_rgb", rgb_3, edge_rgb(t - 4));
        check("lat3_hb", hb_3, edge_hb(t - 4));
      end
    end

    to_cycle(140);
    module_en = 1'b0;
    to_cycle(143);
    check("f1_row3_first", rgb_m, 24);
    to_cycle(150);
    check("f1_row3_last", rgb_m, 31);
    to_cycle(157);
    check("irq_f1", irq_m, 1);
    to_cycle(158);
    check("irq_f1_width", irq_m, 0);
    to_cycle(199);
    check("f2_bg_first", rgb_m, 12'hABC);
    to_cycle(206);
    check("f2_bg_last", rgb_m, 12'hABC);
    to_cycle(209);
    check("f2_hsync_on", hs_m, 0);
    to_cycle(211);
    check("f2_hsync_off", hs_m, 1);
    to_cycle(220);
    check("f2_addr_held", a_m, 0);
    to_cycle(250);
    module_en = 1'b1;
    to_cycle(255);
    check("irq_f2_suppressed", irq_m, 0);
    to_cycle(269);
    check("f2_vsync_on", vs_m, 0);
    to_cycle(297);
    check("f3_px0", rgb_m, 0);
    check("f3_hb", hb_m, 0);
    to_cycle(300);
    check("f3_px3", rgb_m, 3);
    to_cycle(353);
    check("irq_f3", irq_m, 1);
    to_cycle(594);
    check("f6_px3", rgb_m, 3);
    check("f6_addr", a_m, 5);
    check("irq_rises_3f", irq_rise, 3);
    check("irq_cycles_3f", irq_hi, 3);

    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_hsync", hs_m, 1);
    check("mid_rst_vsync", vs_m, 1);
    check("mid_rst_hbrank", hb_m, 1);
    check("mid_rst_vbrank", vb_m, 1);
    check("mid_rst_rgb", rgb_m, 0);
    check("mid_rst_irq", irq_m, 0);
    check("mid_rst_addr", a_m, 0);
    check("mid_rst_line", ln_m, 0);
    check("mid_rst_scale_addr", a_s, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    to_cycle(3);
    check("post_rst_bg", rgb_m, 12'hABC);
    to_cycle(101);
    check("post_rst_px0", rgb_m, 0);
    check("post_rst_hb", hb_m, 0);
    to_cycle(102);
    check("post_rst_px1", rgb_m, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
